// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if: per-channel enable/ratio/sync inputs
// and divided clock / tick outputs of the divider bank.
interface clk_div_bank_if #(
   parameter int NUM_CH      = 4,
   parameter int RATIO_WIDTH = 8
);
   logic [NUM_CH-1:0]             i_clk_en;
   logic [NUM_CH*RATIO_WIDTH-1:0] i_div_ratio;
   logic                          i_sync;
   logic [NUM_CH-1:0]             o_div_clk;
   logic [NUM_CH-1:0]             o_tick;

   modport master (
      output i_clk_en,
      output i_div_ratio,
      output i_sync,
      input  o_div_clk,
      input  o_tick
   );

   modport slave (
      input  i_clk_en,
      input  i_div_ratio,
      input  i_sync,
      output o_div_clk,
      output o_tick
   );
endinterface

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH glitch-free integer dividers with period ticks.
// Optional phase-align input compiled in by CLK_DIV_PHASE_SYNC_EN.
module clk_div_bank #(
   parameter int RATIO_WIDTH = 8,
   parameter int NUM_CH      = 4
) (
   input  logic          i_ref_clk,
   input  logic          i_rst,
   clk_div_bank_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2
   } state_e;

   typedef logic [RATIO_WIDTH-1:0] ratio_t;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_e               state_q, state_d;
      ratio_t               cnt_q, cnt_d;
      ratio_t               n_q, n_d;
      logic                 div_clk_q, div_clk_d;
      logic                 tick_q, tick_d;
      logic                 en_w, sync_hit;
      logic                 reload, go_idle;
      ratio_t               ratio_w;
      logic [RATIO_WIDTH:0] half_w;

      assign en_w    = bus.i_clk_en[c];
      assign ratio_w = bus.i_div_ratio[c*RATIO_WIDTH +: RATIO_WIDTH];

`ifdef CLK_DIV_PHASE_SYNC_EN
      assign sync_hit = bus.i_sync & en_w;
`else
      assign sync_hit = 1'b0;
`endif

      // Boundary decisions, period restart and registered output values
      always_comb begin
         state_d   = state_q;
         cnt_d     = cnt_q;
         n_d       = n_q;
         reload    = 1'b0;
         go_idle   = 1'b0;
         half_w    = '0;
         div_clk_d = 1'b0;
         tick_d    = 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (en_w) reload = 1'b1;
            end
            ST_RUN: begin
               if (cnt_q == n_q - ratio_t'(1)) begin
                  if (en_w) reload  = 1'b1;
                  else      go_idle = 1'b1;
               end else begin
                  cnt_d = cnt_q + ratio_t'(1);
               end
            end
            ST_PASS: begin
               if (en_w) reload  = 1'b1;
               else      go_idle = 1'b1;
            end
            default: go_idle = 1'b1;
         endcase
         // sync wins over whatever the boundary logic decided
         if (sync_hit) begin
            reload  = 1'b1;
            go_idle = 1'b0;
         end
         if (go_idle) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         if (reload) begin
            n_d     = ratio_w;
            cnt_d   = '0;
            state_d = (ratio_w >= ratio_t'(2)) ? ST_RUN : ST_PASS;
         end
         // odd ratios put the extra cycle in the high phase
         half_w    = ({1'b0, n_d} + 1'b1) >> 1;
         div_clk_d = (state_d == ST_RUN) && ({1'b0, cnt_d} < half_w);
         tick_d    = ((state_d == ST_RUN) && (cnt_d == '0))
                   || (state_d == ST_PASS);
      end

      // Channel state and output registers, synchronous active-low reset
      always_ff @(posedge i_ref_clk) begin
         if (!i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            n_q       <= '0;
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
         end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
         end
      end

      assign bus.o_div_clk[c] = div_clk_q;
      assign bus.o_tick[c]    = tick_q;
   end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: vector table, directed corner sequences and
// randomized traffic against a waveform-queue reference model.
module tb_clk_div_bank;
   localparam int NUM_CH = 4;
   localparam int RW     = 8;

`ifdef CLK_DIV_PHASE_SYNC_EN
   localparam bit SYNC_ON = 1'b1;
`else
   localparam bit SYNC_ON = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NUM_CH-1:0]    en;
   logic [NUM_CH*RW-1:0] ratio;
   logic                 sync;

   int n_pass  = 0;
   int n_total = 0;

   clk_div_bank_if #(.NUM_CH(NUM_CH), .RATIO_WIDTH(RW)) bus ();

   assign bus.i_clk_en    = en;
   assign bus.i_div_ratio = ratio;
   assign bus.i_sync      = sync;

   clk_div_bank #(.RATIO_WIDTH(RW), .NUM_CH(NUM_CH)) dut (
      .i_ref_clk (clk),
      .i_rst     (rst),
      .bus       (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference: each channel holds a queue of future {clk,tick}
   // output cycles; an empty queue means the next edge is a boundary.
   logic [1:0]        mq [NUM_CH][$];
   logic [NUM_CH-1:0] m_clk;
   logic [NUM_CH-1:0] m_tick;

   function automatic void push_period(int c, int n);
      logic [1:0] v;
      if (n < 2) begin
         mq[c].push_back(2'b01);
      end else begin
         for (int k = 0; k < n; k++) begin
            v = {k < (n + 1) / 2, k == 0};
            mq[c].push_back(v);
         end
      end
   endfunction

   function automatic void model_edge();
      logic [1:0] v;
      int n;
      for (int c = 0; c < NUM_CH; c++) begin
         n = int'(ratio[c*RW +: RW]);
         if (!rst) begin
            mq[c].delete();
         end else if (SYNC_ON && sync && en[c]) begin
            mq[c].delete();
            push_period(c, n);
         end else if (mq[c].size() == 0 && en[c]) begin
            push_period(c, n);
         end
         if (mq[c].size() > 0) begin
            v = mq[c].pop_front();
            m_clk[c]  = v[1];
            m_tick[c] = v[0];
         end else begin
            m_clk[c]  = 1'b0;
            m_tick[c] = 1'b0;
         end
      end
   endfunction

   function automatic void check(string nm, logic [15:0] got,
                                 logic [15:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t",
                    nm, got, exp, $time);
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("model_div_clk", 16'(bus.o_div_clk), 16'(m_clk));
      check("model_tick", 16'(bus.o_tick), 16'(m_tick));
   endtask

   task automatic do_reset();
      en    = '0;
      ratio = '0;
      sync  = 1'b0;
      rst   = 1'b0;
      step();
      rst   = 1'b1;
   endtask

   task automatic set_ratio(int c, int n);
      ratio[c*RW +: RW] = RW'(n);
   endtask

   typedef struct {
      int          ch;
      int          n;
      int          len;
      logic [15:0] clk_p;
      logic [15:0] tick_p;
   } vec_t;

   vec_t vt [7];

   initial begin
      logic [15:0] p_clk;
      logic [15:0] p_tick;
      logic [15:0] exp_v;

      vt[0] = '{0, 4,  8, 16'hCC00, 16'h8800};
      vt[1] = '{1, 5, 10, 16'hE700, 16'h8400};
      vt[2] = '{2, 2,  8, 16'hAA00, 16'hAA00};
      vt[3] = '{3, 3,  9, 16'hDB00, 16'h9200};
      vt[4] = '{0, 1,  4, 16'h0000, 16'hF000};
      vt[5] = '{1, 0,  4, 16'h0000, 16'hF000};
      vt[6] = '{2, 7, 14, 16'hF1E0, 16'h8100};

      en    = '0;
      ratio = '0;
      sync  = 1'b0;
      rst   = 1'b0;
      step();
      check("reset_div_clk", 16'(bus.o_div_clk), 16'h0);
      check("reset_tick", 16'(bus.o_tick), 16'h0);

      for (int v = 0; v < 7; v++) begin
         do_reset();
         set_ratio(vt[v].ch, vt[v].n);
         en[vt[v].ch] = 1'b1;
         for (int i = 0; i < vt[v].len; i++) begin
            step();
            check("tbl_div_clk", 16'(bus.o_div_clk[vt[v].ch]),
                  16'(vt[v].clk_p[15-i]));
            check("tbl_tick", 16'(bus.o_tick[vt[v].ch]),
                  16'(vt[v].tick_p[15-i]));
         end
      end

      // ratio 5 -> 2 mid-period: old period finishes first
      do_reset();
      set_ratio(1, 5);
      en[1] = 1'b1;
      step();
      step();
      set_ratio(1, 2);
      p_clk  = 16'b10010101;
      p_tick = 16'b00010101;
      for (int i = 0; i < 8; i++) begin
         step();
         check("seq_ratio_clk", 16'(bus.o_div_clk[1]), 16'(p_clk[7-i]));
         check("seq_ratio_tick", 16'(bus.o_tick[1]), 16'(p_tick[7-i]));
      end

      // enable dropped at counter 1 of a 6-cycle period
      do_reset();
      set_ratio(2, 6);
      en[2] = 1'b1;
      step();
      step();
      en[2] = 1'b0;
      p_clk = 16'b10000000;
      for (int i = 0; i < 8; i++) begin
         step();
         check("seq_dis_clk", 16'(bus.o_div_clk[2]), 16'(p_clk[7-i]));
         check("seq_dis_tick", 16'(bus.o_tick[2]), 16'h0);
      end

      // pass-through at N=1, N=0, then N=3
      do_reset();
      set_ratio(3, 1);
      en[3]  = 1'b1;
      p_clk  = 16'b000000110110;
      p_tick = 16'b111111100100;
      for (int i = 0; i < 12; i++) begin
         if (i == 3) set_ratio(3, 0);
         if (i == 6) set_ratio(3, 3);
         step();
         check("seq_pass_clk", 16'(bus.o_div_clk[3]), 16'(p_clk[11-i]));
         check("seq_pass_tick", 16'(bus.o_tick[3]), 16'(p_tick[11-i]));
      end

      // out-of-phase ch0 N=4 / ch1 N=6, then a sync pulse
      do_reset();
      set_ratio(0, 4);
      set_ratio(1, 6);
      en[0] = 1'b1;
      step();
      en[1] = 1'b1;
      step();
      step();
      sync = 1'b1;
      step();
      sync  = 1'b0;
      exp_v = SYNC_ON ? 16'h3 : 16'h0;
      check("sync_tick", 16'(bus.o_tick[1:0]), exp_v);
      for (int i = 0; i < 6; i++) step();

      // reset mid-period, release with enables held
      do_reset();
      for (int c = 0; c < NUM_CH; c++) set_ratio(c, c + 3);
      en = '1;
      for (int i = 0; i < 7; i++) step();
      rst = 1'b0;
      step();
      check("rst_mid_clk", 16'(bus.o_div_clk), 16'h0);
      check("rst_mid_tick", 16'(bus.o_tick), 16'h0);
      rst = 1'b1;
      step();
      check("rst_rel_clk", 16'(bus.o_div_clk), 16'hF);
      check("rst_rel_tick", 16'(bus.o_tick), 16'hF);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
            if ($urandom_range(0, 7) == 0)
               set_ratio(c, int'($urandom_range(0, 12)));
         end
         sync = ($urandom_range(0, 19) == 0);
         rst  = ($urandom_range(0, 299) != 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel, parametrised integer clock divider. Each of NUM_CH channels produces a registered divided clock and a one-cycle period tick from the single reference clock. Ratio changes and enable/disable are applied only at period boundaries, so outputs never produce runt pulses. An optional sync input phase-aligns all channels. The block feeds the UART/SPI baud and sample-enable logic.

## Interface
- RATIO_WIDTH, 8, width of each channel's division ratio
- NUM_CH, 4, number of independent divider channels
- i_ref_clk  input  1  reference clock; all logic on its rising edge
- i_rst  input  1  synchronous, active-low reset, sampled on the i_ref_clk rising edge
- i_clk_en  input  NUM_CH  per-channel run enable
- i_div_ratio  input  NUM_CH*RATIO_WIDTH  per-channel ratio; channel c uses bits [c*RATIO_WIDTH +: RATIO_WIDTH]
- i_sync  input  1  phase-align pulse; ignored unless CLK_DIV_PHASE_SYNC_EN is defined
- o_div_clk  output  NUM_CH  registered divided clock per channel
- o_tick  output  NUM_CH  one-cycle strobe at the start of each period (rising edge of o_div_clk)

## Operation
- Reset (i_rst=0 at an edge): all counters, active ratios, o_div_clk and o_tick are 0; every channel is IDLE.
- Per-channel state: IDLE, RUN, PASS. Active ratio N is a shadow register, loaded from i_div_ratio only when a new period starts.
- IDLE: o_div_clk=0, o_tick=0. If i_clk_en[c]=1, load N. If N>=2, go to RUN at period start. If N is 0 or 1, go to PASS.
- RUN period of N cycles:
  - o_div_clk high for H=ceil(N/2) cycles, then low for L=floor(N/2) cycles.
  - o_tick is 1 only in the first high cycle.
  - The counter runs 0..N-1, uses RATIO_WIDTH bits and wraps at N-1.
- Period boundary (RUN, counter=N-1):
  - If i_clk_en[c]=0, go to IDLE. The output is already low.
  - Else reload N from i_div_ratio. If the new N>=2, start a new period. If the new N<2, go to PASS.
- PASS (divide-by-1): o_div_clk=0 and o_tick=1 every cycle. Every cycle is a boundary, so enable and ratio are re-evaluated each cycle. A ratio >=2 moves the channel to RUN with period start on the next cycle. Enable low moves it to IDLE.
- Deasserting i_clk_en mid-period never truncates the period. The current period completes, then the channel idles.
- A ratio change mid-period has no effect until the boundary.
- Channels are fully independent except for i_sync.
- i_sync (macro enabled), i_sync=1 at an edge:
  - Every channel with i_clk_en[c]=1 and i_div_ratio>=2 reloads N and restarts the period: counter 0, o_div_clk=1, o_tick=1 on the next cycle.
  - Channels with i_clk_en=0 are unaffected.
  - Enabled channels whose ratio is <2 enter or stay in PASS.
  - Sync overrides any in-progress period, including a pending boundary in the same cycle.
  - Sync has priority over the normal boundary reload.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Enable latency: i_clk_en[c] rises, sampled at edge t. o_div_clk[c]=1 and o_tick[c]=1 from edge t through edge t+1.
- Sync latency: i_sync sampled at edge t gives period start after edge t.
- The ratio is sampled in the last cycle of a period (counter=N-1) and governs the period that starts after that edge.
- Period is exactly N i_ref_clk cycles. Odd N puts the extra cycle in the high phase.
- Reset takes effect at the first edge with i_rst=0, including mid-period. Outputs are 0 after that edge.

## Configuration
- CLK_DIV_PHASE_SYNC_EN:
  - Defined: the i_sync logic is compiled in as described above.
  - Undefined: the i_sync port remains but is unconnected internally. Channels only align through enable and boundaries, and the sync priority logic is absent.

## Test plan
- Reset, then enable ch0 with N=4: o_div_clk pattern 1100 repeating; o_tick at period starts, every 4 cycles.
- ch1 with N=5: high 3 cycles, low 2 cycles, period 5. Change the ratio to 2 mid-period: the current 5-cycle period completes, then the pattern is 10 repeating.
- ch2 with N=6: deassert enable at counter=1. The output stays high through cycle 2, low for cycles 3-5, then idles at 0 with no further ticks.
- ch3 with N=1, then N=0: o_tick=1 every cycle, o_div_clk=0. Switch to N=3: pattern 110 begins one cycle after the boundary.
- With the macro defined, ch0 N=4 and ch1 N=6 out of phase: pulse i_sync. Both have o_tick=1 on the same cycle after the pulse. With the macro undefined, the same stimulus leaves the phases unchanged.
- Assert i_rst=0 mid-period on all channels: all outputs are 0 after the edge. Release reset with enables held: all channels start a period together on the first cycle after the release edge.
